pattern_stream_gen: RTL and testbench

- Parametrised successor to the single-stream data generator.
- Emits an AXI4-Stream of `size` beats with selectable data pattern and seed.
- Optionally splits the transfer into packets of `pkt_len` beats, each ending with TLAST.
- Controlled by an HLS-style ap_ctrl_hs handshake; feeds AXI-MM writer/DMA blocks in cocotb benches.

---
 rtl/pattern_stream_gen.sv | 204 ++++++++++++++++++++
 tb/tb_pattern_stream_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_stream_gen.sv
// AXI4-Stream pattern generator with ap_ctrl_hs control and optional packetisation.
// Optional first-beat-of-packet sideband: define PATTERN_STREAM_GEN_TUSER_EN to add m_axis_tuser.
module pattern_stream_gen #(
   parameter int unsigned       WIDTH     = 8,
   parameter logic [WIDTH-1:0]  LFSR_TAPS = WIDTH'(8'hB8)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       size,
   input  logic [15:0]       pkt_len,
   input  logic [1:0]        mode,
   input  logic [WIDTH-1:0]  seed,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   output logic [WIDTH-1:0]  m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
`ifdef PATTERN_STREAM_GEN_TUSER_EN
   output logic              m_axis_tuser,
`endif
   input  logic              m_axis_tready,
   output logic [31:0]       beat_count
);

   localparam int unsigned CNT_W = 32;
   localparam int unsigned PKT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_size;
   logic [PKT_W-1:0]   r_pkt_len;
   logic [1:0]         r_mode;
   logic [WIDTH-1:0]   r_data;
   logic               r_valid;
   logic               r_last;
   logic [CNT_W-1:0]   r_beat_cnt;
   logic [PKT_W-1:0]   r_pkt_cnt;
   logic               r_ready;
   logic               r_done;
   logic               r_idle;

   state_t             w_state_nxt;
   logic [CNT_W-1:0]   w_size_nxt;
   logic [PKT_W-1:0]   w_pkt_len_nxt;
   logic [1:0]         w_mode_nxt;
   logic [WIDTH-1:0]   w_data_nxt;
   logic               w_valid_nxt;
   logic               w_last_nxt;
   logic [CNT_W-1:0]   w_beat_nxt;
   logic [PKT_W-1:0]   w_pkt_nxt;
   logic               w_ready_nxt;
   logic               w_accept;

   // Seed 0 would lock up the LFSR and the walking-one pattern, so substitute a live value.
   function automatic logic [WIDTH-1:0] init_pattern(input logic [1:0] md, input logic [WIDTH-1:0] sd);
      logic [WIDTH-1:0] v;
      v = sd;
      if (sd == '0) begin
         if (md == 2'd2) v = '1;
         else if (md == 2'd3) v = WIDTH'(1);
      end
      return v;
   endfunction

   function automatic logic [WIDTH-1:0] next_pattern(input logic [1:0] md, input logic [WIDTH-1:0] cur);
      logic [WIDTH-1:0] v;
      v = cur;
      case (md)
         2'd0:    v = cur + WIDTH'(1);
         2'd1:    v = cur;
         2'd2:    v = {cur[WIDTH-2:0], ^(cur & LFSR_TAPS)};
         default: v = {cur[WIDTH-2:0], cur[WIDTH-1]};
      endcase
      return v;
   endfunction

   assign w_accept = r_valid & m_axis_tready;

   // State and datapath register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_size     <= '0;
         r_pkt_len  <= '0;
         r_mode     <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_beat_cnt <= '0;
         r_pkt_cnt  <= '0;
         r_ready    <= 1'b0;
         r_done     <= 1'b0;
         r_idle     <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_size     <= w_size_nxt;
         r_pkt_len  <= w_pkt_len_nxt;
         r_mode     <= w_mode_nxt;
         r_data     <= w_data_nxt;
         r_valid    <= w_valid_nxt;
         r_last     <= w_last_nxt;
         r_beat_cnt <= w_beat_nxt;
         r_pkt_cnt  <= w_pkt_nxt;
         r_ready    <= w_ready_nxt;
         r_done     <= (w_state_nxt == S_DONE);
         r_idle     <= (w_state_nxt == S_IDLE);
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_size_nxt    = r_size;
      w_pkt_len_nxt = r_pkt_len;
      w_mode_nxt    = r_mode;
      w_data_nxt    = r_data;
      w_valid_nxt   = r_valid;
      w_last_nxt    = r_last;
      w_beat_nxt    = r_beat_cnt;
      w_pkt_nxt     = r_pkt_cnt;
      w_ready_nxt   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (ap_start) begin
               w_size_nxt    = size;
               w_pkt_len_nxt = pkt_len;
               w_mode_nxt    = mode;
               w_data_nxt    = init_pattern(mode, seed);
               w_beat_nxt    = '0;
               w_pkt_nxt     = '0;
               w_ready_nxt   = 1'b1;
               if (size == '0) begin
                  w_state_nxt = S_DONE;
                  w_valid_nxt = 1'b0;
                  w_last_nxt  = 1'b0;
               end else begin
                  w_state_nxt = S_RUN;
                  w_valid_nxt = 1'b1;
                  w_last_nxt  = (pkt_len == PKT_W'(1)) || (size == CNT_W'(1));
               end
            end
         end
         S_RUN: begin
            if (w_accept) begin
               w_beat_nxt = r_beat_cnt + CNT_W'(1);
               w_data_nxt = next_pattern(r_mode, r_data);
               w_pkt_nxt  = r_last ? '0 : r_pkt_cnt + PKT_W'(1);
               if (r_beat_cnt == r_size - CNT_W'(1)) begin
                  w_state_nxt = S_DONE;
                  w_valid_nxt = 1'b0;
                  w_last_nxt  = 1'b0;
               end else begin
                  w_last_nxt = ((r_pkt_len != '0) && (w_pkt_nxt == r_pkt_len - PKT_W'(1)))
                             || (w_beat_nxt == r_size - CNT_W'(1));
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
         end
      endcase
   end

`ifdef PATTERN_STREAM_GEN_TUSER_EN
   logic r_user;
   logic w_user_nxt;

   // With pkt_len==0 the packet counter free-runs, so only the very first beat starts a packet.
   always_comb begin
      w_user_nxt = 1'b0;
      if (w_state_nxt == S_RUN)
         w_user_nxt = (w_pkt_nxt == '0) && ((w_pkt_len_nxt != '0) || (w_beat_nxt == '0));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) r_user <= 1'b0;
      else          r_user <= w_user_nxt;
   end

   assign m_axis_tuser = r_user;
`endif

   assign ap_done       = r_done;
   assign ap_idle       = r_idle;
   assign ap_ready      = r_ready;
   assign m_axis_tdata  = r_data;
   assign m_axis_tvalid = r_valid;
   assign m_axis_tlast  = r_last;
   assign beat_count    = r_beat_cnt;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Randomised bench for pattern_stream_gen against a closed-form per-beat reference model.
module tb_pattern_stream_gen;
   localparam int unsigned W = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [31:0]   size;
   logic [15:0]   pkt_len;
   logic [1:0]    mode;
   logic [W-1:0]  seed;
   logic          ap_start;
   logic          ap_done;
   logic          ap_idle;
   logic          ap_ready;
   logic [W-1:0]  m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready;
   logic [31:0]   beat_count;
`ifdef PATTERN_STREAM_GEN_TUSER_EN
   logic          m_axis_tuser;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pattern_stream_gen #(.WIDTH(W)) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .size          (size),
      .pkt_len       (pkt_len),
      .mode          (mode),
      .seed          (seed),
      .ap_start      (ap_start),
      .ap_done       (ap_done),
      .ap_idle       (ap_idle),
      .ap_ready      (ap_ready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
`ifdef PATTERN_STREAM_GEN_TUSER_EN
      .m_axis_tuser  (m_axis_tuser),
`endif
      .m_axis_tready (m_axis_tready),
      .beat_count    (beat_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Value of beat idx (0-based) computed directly from the pattern definitions.
   function automatic logic [W-1:0] model_data(input logic [1:0] md, input logic [W-1:0] sd,
                                               input int unsigned idx);
      logic [W-1:0] v;
      logic [W-1:0] taps;
      int unsigned  r;
      taps = W'(8'hB8);
      r    = idx % W;
      case (md)
         2'd0: v = W'((32'(sd) + idx) % (32'd1 << W));
         2'd1: v = sd;
         2'd2: begin
            v = (sd == '0) ? '1 : sd;
            for (int unsigned k = 0; k < idx; k++) v = {v[W-2:0], ^(v & taps)};
         end
         default: begin
            v = (sd == '0) ? W'(1) : sd;
            if (r != 0) v = W'((v << r) | (v >> (W - r)));
         end
      endcase
      return v;
   endfunction

   // rdy_mode: 0 always ready, 1 toggle 1/0 each cycle, 2 random.
   task automatic run_xfer(input int unsigned sz, input int unsigned pl, input logic [1:0] md,
                           input logic [W-1:0] sd, input int rdy_mode, input bit keep_start);
      int unsigned i;
      int unsigned cyc;
      bit          tog;
      bit          el;
      bit          eu;
      size     = sz;
      pkt_len  = 16'(pl);
      mode     = md;
      seed     = sd;
      ap_start = 1'b1;
      check("idle_before_start", 32'(ap_idle), 32'd1);
      tick;
      if (!keep_start) ap_start = 1'b0;
      check("ap_ready_pulse", 32'(ap_ready), 32'd1);
      check("idle_low_after_start", 32'(ap_idle), 32'd0);
      check("beat_count_cleared", beat_count, 32'd0);
      if (sz == 0) begin
         check("tvalid_size0", 32'(m_axis_tvalid), 32'd0);
         check("done_size0", 32'(ap_done), 32'd1);
         tick;
         check("done_size0_one_cycle", 32'(ap_done), 32'd0);
         check("idle_after_size0", 32'(ap_idle), 32'd1);
         check("ready_size0_one_cycle", 32'(ap_ready), 32'd0);
         return;
      end
      i   = 0;
      cyc = 0;
      tog = 1'b1;
      while (i < sz) begin
         if (cyc > sz * 4 + 50) begin
            check("beat_timeout", 32'd1, 32'd0);
            break;
         end
         el = ((pl != 0) && ((i % pl) == pl - 1)) || (i == sz - 1);
         eu = (pl != 0) ? ((i % pl) == 0) : (i == 0);
         check("tvalid", 32'(m_axis_tvalid), 32'd1);
         check("tdata", 32'(m_axis_tdata), 32'(model_data(md, sd, i)));
         check("tlast", 32'(m_axis_tlast), 32'(el));
`ifdef PATTERN_STREAM_GEN_TUSER_EN
         check("tuser", 32'(m_axis_tuser), 32'(eu));
`endif
         check("done_during_run", 32'(ap_done), 32'd0);
         check("beat_count_run", beat_count, i);
         if (cyc > 0) check("ready_one_cycle", 32'(ap_ready), 32'd0);
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       begin m_axis_tready = tog; tog = ~tog; end
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
         if (!keep_start) ap_start = 1'($urandom_range(0, 1));
         tick;
         if (m_axis_tready) i++;
         cyc++;
      end
      if (!keep_start) ap_start = 1'b0;
      check("tvalid_after_last", 32'(m_axis_tvalid), 32'd0);
      check("tlast_after_last", 32'(m_axis_tlast), 32'd0);
      check("done_pulse", 32'(ap_done), 32'd1);
      check("idle_low_in_done", 32'(ap_idle), 32'd0);
      check("beat_count_final", beat_count, sz);
      tick;
      check("done_one_cycle", 32'(ap_done), 32'd0);
      check("idle_after_done", 32'(ap_idle), 32'd1);
      check("beat_count_holds", beat_count, sz);
   endtask

   initial begin
      reset_n       = 1'b0;
      size          = '0;
      pkt_len       = '0;
      mode          = '0;
      seed          = '0;
      ap_start      = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) tick;
      check("rst_idle", 32'(ap_idle), 32'd1);
      check("rst_done", 32'(ap_done), 32'd0);
      check("rst_ready", 32'(ap_ready), 32'd0);
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_tlast", 32'(m_axis_tlast), 32'd0);
      check("rst_tdata", 32'(m_axis_tdata), 32'd0);
      check("rst_beat_count", beat_count, 32'd0);
      reset_n = 1'b1;
      tick;

      // Increment wrap, single packet
      run_xfer(4, 0, 2'd0, 8'hFE, 0, 1'b0);
      // Packetised with short final packet
      run_xfer(10, 4, 2'd0, 8'h10, 0, 1'b0);
      // LFSR seed substitution with alternating backpressure
      run_xfer(3, 0, 2'd2, 8'h00, 1, 1'b0);
      // Empty transfer
      run_xfer(0, 0, 2'd1, 8'h5A, 0, 1'b0);
      // Walking-one seed substitution, one-beat packets
      run_xfer(9, 1, 2'd3, 8'h00, 2, 1'b0);

      // Mid-transfer reset drops the in-flight beat
      size = 32'd5; pkt_len = '0; mode = 2'd3; seed = 8'h80;
      m_axis_tready = 1'b1;
      ap_start = 1'b1;
      tick;
      ap_start = 1'b0;
      check("rstmid_beat1", 32'(m_axis_tdata), 32'h80);
      tick;
      check("rstmid_beat2", 32'(m_axis_tdata), 32'h01);
      tick;
      check("rstmid_count2", beat_count, 32'd2);
      reset_n = 1'b0;
      tick;
      check("rstmid_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rstmid_tlast", 32'(m_axis_tlast), 32'd0);
      check("rstmid_idle", 32'(ap_idle), 32'd1);
      check("rstmid_done", 32'(ap_done), 32'd0);
      check("rstmid_count", beat_count, 32'd0);
      reset_n = 1'b1;
      tick;
      check("rstmid_post_done", 32'(ap_done), 32'd0);
      check("rstmid_post_tvalid", 32'(m_axis_tvalid), 32'd0);

      // Held ap_start: back-to-back transfers with one visible IDLE cycle
      run_xfer(2, 0, 2'd0, 8'h30, 0, 1'b1);
      run_xfer(2, 0, 2'd1, 8'h44, 2, 1'b0);

      // Randomised transfers
      for (int n = 0; n < 40; n++) begin
         run_xfer($urandom_range(0, 24), $urandom_range(0, 6), 2'($urandom_range(0, 3)),
                  W'($urandom), 2, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
